gate_sweep_ctrl: RTL and testbench



---
 rtl/gate_sweep_ctrl.sv | 128 ++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - exhaustive truth-table sweep comparing two gate implementations
// Optional: GATE_SWEEP_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module gate_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            res_a,
    input  logic            res_b,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            first_err_valid,
    output logic [N_IN-1:0] first_err_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

`ifdef GATE_SWEEP_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam state_t     AFTER_VEC  = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    state_t          state, state_nx;
    logic [3:0]      cnt, cnt_nx;
    logic [N_IN-1:0] vec_nx, first_err_vec_nx;
    logic [N_IN:0]   err_cnt_nx;
    logic            busy_nx, done_nx, pass_nx, first_err_valid_nx;
    logic            mismatch;

    assign mismatch = res_a ^ res_b;

    always_comb begin
        state_nx           = state;
        cnt_nx             = cnt;
        vec_nx             = vec;
        busy_nx            = busy;
        done_nx            = 1'b0;
        pass_nx            = pass;
        err_cnt_nx         = err_cnt;
        first_err_valid_nx = first_err_valid;
        first_err_vec_nx   = first_err_vec;
        case (state)
            S_IDLE: begin
                if (start) begin
                    vec_nx             = '0;
                    err_cnt_nx         = '0;
                    first_err_valid_nx = 1'b0;
                    first_err_vec_nx   = '0;
                    pass_nx            = 1'b0;
                    busy_nx            = 1'b1;
                    cnt_nx             = SETTLE_CNT;
                    state_nx           = AFTER_VEC;
                end
            end
            S_SETTLE: begin
                cnt_nx = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nx = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_cnt_nx = err_cnt + (N_IN+1)'(1);
                    if (!first_err_valid) begin
                        first_err_vec_nx   = vec;
                        first_err_valid_nx = 1'b1;
                    end
                end
                // busy drops and done rises together so done lands in the DONE cycle
                if ((&vec) || (STOP_ON_ERR && mismatch)) begin
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    pass_nx  = !mismatch && (err_cnt == '0);
                    state_nx = S_DONE;
                end else begin
                    vec_nx   = vec + N_IN'(1);
                    cnt_nx   = SETTLE_CNT;
                    state_nx = AFTER_VEC;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            vec             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            vec             <= vec_nx;
            busy            <= busy_nx;
            done            <= done_nx;
            pass            <= pass_nx;
            err_cnt         <= err_cnt_nx;
            first_err_valid <= first_err_valid_nx;
            first_err_vec   <= first_err_vec_nx;
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - self-checking bench for gate_sweep_ctrl (SETTLE=1 and SETTLE=0 instances)
module tb_gate_sweep_ctrl;

    logic clk;
    logic rst_n;
    logic start;
    int   mode;

    logic       ra1, rb1, ra0, rb0;
    logic [1:0] vec1, vec0, fev1, fev0;
    logic       busy1, busy0, done1, done0, pass1, pass0, fvl1, fvl0;
    logic [2:0] err1, err0;

    int n_vec = 0;
    int n_bad = 0;

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .res_a(ra1), .res_b(rb1),
        .vec(vec1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_valid(fvl1), .first_err_vec(fev1)
    );

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start), .res_a(ra0), .res_b(rb0),
        .vec(vec0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_err_valid(fvl0), .first_err_vec(fev0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: equal NOR; 1: NOR vs NAND; 2: constant 0 vs 1; 3: differ only at vec=1
    function automatic logic f_a(input int md, input logic [1:0] v);
        return (md == 2) ? 1'b0 : ~(v[0] | v[1]);
    endfunction

    function automatic logic f_b(input int md, input logic [1:0] v);
        case (md)
            0:       return ~(v[0] | v[1]);
            1:       return ~v[0] | ~v[1];
            2:       return 1'b1;
            default: return ~(v[0] | v[1]) ^ (v == 2'd1);
        endcase
    endfunction

    // Mismatch truth table per mode, bit v set when vector v must miscompare
    function automatic logic [3:0] mask_of(input int md);
        case (md)
            0:       return 4'b0000;
            1:       return 4'b0110;
            2:       return 4'b1111;
            default: return 4'b0010;
        endcase
    endfunction

    always_comb begin
        ra1 = f_a(mode, vec1);
        rb1 = f_b(mode, vec1);
        ra0 = f_a(mode, vec0);
        rb0 = f_b(mode, vec0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // Model index 0 tracks u_s1 (SETTLE=1), index 1 tracks u_s0 (SETTLE=0)
    bit         m_run [2];
    int         m_m   [2];
    int         m_md  [2];
    logic [1:0] e_vec [2];
    logic       e_busy[2];
    logic       e_done[2];
    logic       e_pass[2];
    logic [2:0] e_err [2];
    logic       e_fvl [2];
    logic [1:0] e_fev [2];

    task automatic model_step(input int d);
        int s1, last, total, e, fv;
        bit fvl;
        logic [3:0] mk;
        s1 = (d == 0) ? 2 : 1;
        if (!m_run[d]) begin
            if (!start) return;
            m_run[d] = 1'b1;
            m_m[d]   = 0;
            m_md[d]  = mode;
        end else begin
            m_m[d]++;
        end
        mk   = mask_of(m_md[d]);
        last = 3;
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
        for (int v = 3; v >= 0; v--) if (mk[v]) last = v;
`endif
        total = (last + 1) * s1;
        e = 0; fv = 0; fvl = 1'b0;
        for (int v = 0; v <= last; v++) begin
            if (mk[v] && ((v + 1) * s1 <= m_m[d])) begin
                e++;
                if (!fvl) begin
                    fvl = 1'b1;
                    fv  = v;
                end
            end
        end
        if (m_m[d] <= total) begin
            e_err[d] = 3'(e);
            e_fvl[d] = fvl;
            e_fev[d] = 2'(fv);
        end
        if (m_m[d] < total) begin
            e_busy[d] = 1'b1;
            e_done[d] = 1'b0;
            e_pass[d] = 1'b0;
            e_vec[d]  = 2'(m_m[d] / s1);
        end else if (m_m[d] == total) begin
            e_busy[d] = 1'b0;
            e_done[d] = 1'b1;
            e_vec[d]  = 2'(last);
            e_pass[d] = (e == 0);
        end else begin
            e_done[d] = 1'b0;
            m_run[d]  = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_run[d] = 1'b0; m_m[d] = 0; m_md[d] = 0;
                e_vec[d] = '0; e_busy[d] = 1'b0; e_done[d] = 1'b0; e_pass[d] = 1'b0;
                e_err[d] = '0; e_fvl[d] = 1'b0; e_fev[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("s1_vec", 32'(vec1), 32'(e_vec[0]));
            chk("s1_busy", 32'(busy1), 32'(e_busy[0]));
            chk("s1_done", 32'(done1), 32'(e_done[0]));
            chk("s1_pass", 32'(pass1), 32'(e_pass[0]));
            chk("s1_err_cnt", 32'(err1), 32'(e_err[0]));
            chk("s1_first_err_valid", 32'(fvl1), 32'(e_fvl[0]));
            chk("s1_first_err_vec", 32'(fev1), 32'(e_fev[0]));
            chk("s0_vec", 32'(vec0), 32'(e_vec[1]));
            chk("s0_busy", 32'(busy0), 32'(e_busy[1]));
            chk("s0_done", 32'(done0), 32'(e_done[1]));
            chk("s0_pass", 32'(pass0), 32'(e_pass[1]));
            chk("s0_err_cnt", 32'(err0), 32'(e_err[1]));
            chk("s0_first_err_valid", 32'(fvl0), 32'(e_fvl[1]));
            chk("s0_first_err_vec", 32'(fev0), 32'(e_fev[1]));
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_vec"}, 32'(vec1), 0);
        chk({tag, "_busy"}, 32'(busy1), 0);
        chk({tag, "_done"}, 32'(done1), 0);
        chk({tag, "_pass"}, 32'(pass1), 0);
        chk({tag, "_err_cnt"}, 32'(err1), 0);
        chk({tag, "_first_err_valid"}, 32'(fvl1), 0);
        chk({tag, "_first_err_vec"}, 32'(fev1), 0);
    endtask

    // Pulse start and observe one instance for 40 cycles, interval 1 is the cycle after the start edge
    task automatic run_sweep(input int d, output int busy_n, output int done_at, output int done_n);
        logic b, dn;
        busy_n = 0; done_at = 0; done_n = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            b  = (d == 0) ? busy1 : busy0;
            dn = (d == 0) ? done1 : done0;
            if (b) busy_n++;
            if (dn) begin
                done_n++;
                if (done_at == 0) done_at = i;
            end
            @(negedge clk);
        end
    endtask

    int  bn, da, dn;
    bit  found;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        mode = 0;
        run_sweep(0, bn, da, dn);
        chk("clean_busy_cycles", 32'(bn), 8);
        chk("clean_done_cycle", 32'(da), 9);
        chk("clean_done_pulses", 32'(dn), 1);
        chk("clean_pass", 32'(pass1), 1);
        chk("clean_err_cnt", 32'(err1), 0);
        chk("clean_first_err_valid", 32'(fvl1), 0);
        chk("clean_vec_hold", 32'(vec1), 3);

        mode = 1;
        run_sweep(0, bn, da, dn);
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
        chk("nand_err_cnt", 32'(err1), 1);
        chk("nand_vec_hold", 32'(vec1), 1);
`else
        chk("nand_err_cnt", 32'(err1), 2);
        chk("nand_vec_hold", 32'(vec1), 3);
`endif
        chk("nand_first_err_vec", 32'(fev1), 1);
        chk("nand_first_err_valid", 32'(fvl1), 1);
        chk("nand_pass", 32'(pass1), 0);

        mode = 2;
        run_sweep(1, bn, da, dn);
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
        chk("const_busy_cycles", 32'(bn), 1);
        chk("const_err_cnt", 32'(err0), 1);
`else
        chk("const_busy_cycles", 32'(bn), 4);
        chk("const_err_cnt", 32'(err0), 4);
`endif
        chk("const_first_err_vec", 32'(fev0), 0);
        chk("const_pass", 32'(pass0), 0);

        mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (done1) dn++;
            @(negedge clk);
        end
        chk("midstart_done_pulses", 32'(dn), 1);
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
        chk("midstart_err_cnt", 32'(err1), 1);
`else
        chk("midstart_err_cnt", 32'(err1), 2);
`endif

        mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (vec1 == 2'd2) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_vec2", 32'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clk);
        chk("abort_no_done", 32'(done1), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(0, bn, da, dn);
        chk("after_abort_busy_cycles", 32'(bn), 8);
        chk("after_abort_pass", 32'(pass1), 1);
        chk("after_abort_err_cnt", 32'(err1), 0);

        mode = 3;
        run_sweep(0, bn, da, dn);
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
        chk("vec1_done_cycle", 32'(da), 5);
        chk("vec1_vec_hold", 32'(vec1), 1);
`else
        chk("vec1_done_cycle", 32'(da), 9);
        chk("vec1_vec_hold", 32'(vec1), 3);
`endif
        chk("vec1_err_cnt", 32'(err1), 1);
        chk("vec1_first_err_vec", 32'(fev1), 1);
        chk("vec1_pass", 32'(pass1), 0);

        mode = 1;
        start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("held_start_idle", 32'(busy1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
